// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between register responses, RR-period reports and
// event flags. Sources are buffered, arbitrated only between frames, and fed out byte by byte.
module uart_tx_scheduler #(
  parameter logic [7:0] RR_HDR     = 8'hA5,
  parameter logic [3:0] EVT_PREFIX = 4'hE,
  parameter int         GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  output logic        rsp_ready,
  input  logic        rr_valid,
  input  logic [10:0] rr_period,
  input  logic [3:0]  evt_req,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        rr_ovr_clr,
  output logic        rr_overrun,
  output logic        idle
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP} state_t;

  state_t      r_state, w_next;
  logic        r_rsp_pend;
  logic [7:0]  r_rsp_buf;
  logic        r_rr_pend;
  logic [10:0] r_rr_buf;
  logic [3:0]  r_pend_mask;
  logic [23:0] r_shift;
  logic [1:0]  r_len;
  logic [7:0]  r_gap_cnt;
  logic        r_overrun;

  logic        w_idle_st, w_sel_rsp, w_sel_rr, w_sel_evt, w_more, w_gap_done;
  logic [3:0]  w_evt_oh;

  assign w_idle_st  = (r_state == S_IDLE);
  assign w_sel_rsp  = w_idle_st & r_rsp_pend;
  assign w_sel_rr   = w_idle_st & ~r_rsp_pend & r_rr_pend;
  assign w_sel_evt  = w_idle_st & ~r_rsp_pend & ~r_rr_pend & (|r_pend_mask);
  // Isolate the lowest pending event bit
  assign w_evt_oh   = r_pend_mask & (~r_pend_mask + 4'd1);
  assign w_more     = (r_len > 2'd1);
  assign w_gap_done = (r_state == S_GAP) && (r_gap_cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    tx_data_valid = 1'b0;
    case (r_state)
      S_IDLE:      if (w_sel_rsp | w_sel_rr | w_sel_evt) w_next = S_ISSUE;
      S_ISSUE: begin
        tx_data_valid = 1'b1;
        if (tx_busy) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (!tx_busy) w_next = S_GAP;
      S_GAP:       if (r_gap_cnt == 8'd0) w_next = w_more ? S_ISSUE : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_pend  <= 1'b0;
      r_rsp_buf   <= 8'h00;
      r_rr_pend   <= 1'b0;
      r_rr_buf    <= 11'h000;
      r_pend_mask <= 4'h0;
      r_shift     <= 24'h0;
      r_len       <= 2'd0;
      r_gap_cnt   <= 8'd0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_sel_rsp) r_rsp_pend <= 1'b0;
      else if (rsp_valid && !r_rsp_pend) begin
        r_rsp_pend <= 1'b1;
        r_rsp_buf  <= rsp_data;
      end

      // A new report arriving on the selection cycle simply pends again
      if (rr_valid) begin
        r_rr_buf  <= rr_period;
        r_rr_pend <= 1'b1;
      end else if (w_sel_rr) r_rr_pend <= 1'b0;

      if (rr_valid && r_rr_pend && !w_sel_rr) r_overrun <= 1'b1;
      else if (rr_ovr_clr)                    r_overrun <= 1'b0;

      r_pend_mask <= (r_pend_mask & ~(w_sel_evt ? w_evt_oh : 4'h0)) | evt_req;

      if (w_sel_rsp) begin
        r_shift <= {r_rsp_buf, 16'h0};
        r_len   <= 2'd1;
      end else if (w_sel_rr) begin
        r_shift <= {RR_HDR, 5'b0, r_rr_buf[10:8], r_rr_buf[7:0]};
        r_len   <= 2'd3;
      end else if (w_sel_evt) begin
        r_shift <= {EVT_PREFIX, w_evt_oh, 16'h0};
        r_len   <= 2'd1;
      end else if (w_gap_done) begin
        if (w_more) r_shift <= {r_shift[15:0], 8'h00};
        r_len <= r_len - 2'd1;
      end

      if (r_state == S_WAIT_DONE && !tx_busy) r_gap_cnt <= 8'(GAP_CYCLES);
      else if (r_state == S_GAP && r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  assign tx_data    = r_shift[23:16];
  assign rsp_ready  = ~r_rsp_pend;
  assign rr_overrun = r_overrun;
  assign idle       = w_idle_st & ~r_rsp_pend & ~r_rr_pend & (r_pend_mask == 4'h0);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized + directed bench: expected bytes are queued in priority order when
// stimulus is issued; a transmitter model pops and compares each accepted byte.
module tb_uart_tx_scheduler;
  localparam int GAP = 16;

  logic        clk, rst_n;
  logic        rsp_valid, rr_valid, tx_busy, rr_ovr_clr;
  logic [7:0]  rsp_data;
  logic [10:0] rr_period;
  logic [3:0]  evt_req;
  logic [7:0]  tx_data;
  logic        tx_data_valid, rsp_ready, rr_overrun, idle;

  uart_tx_scheduler #(.RR_HDR(8'hA5), .EVT_PREFIX(4'hE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rr_valid(rr_valid), .rr_period(rr_period), .evt_req(evt_req),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .rr_ovr_clr(rr_ovr_clr), .rr_overrun(rr_overrun), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int  last_fall;
  bit  have_fall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy 3 cycles after a request, held 20 cycles
  initial begin
    int st, cnt;
    bit first;
    logic [7:0] cur;
    st = 0; cnt = 0; first = 0; cur = 8'h00;
    tx_busy = 1'b0; have_fall = 0; last_fall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; tx_busy = 1'b0;
      end else begin
        case (st)
          0: if (tx_data_valid) begin
            cur = tx_data;
            if (exp_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_byte: got %h expected none (cycle %0d)", tx_data, cyc);
            end else chk("byte", tx_data, exp_q.pop_front());
            if (have_fall) chk("gap_ok", 32'((cyc - last_fall) >= GAP), 1);
            cnt = 3; st = 1;
          end
          1: begin
            chk("vld_hold", tx_data_valid, 1);
            chk("data_hold", tx_data, cur);
            cnt--;
            if (cnt == 0) begin tx_busy = 1'b1; cnt = 20; first = 1; st = 2; end
          end
          default: begin
            if (first) chk("vld_drop", tx_data_valid, 0);
            first = 0;
            cnt--;
            if (cnt == 0) begin tx_busy = 1'b0; last_fall = cyc; have_fall = 1; st = 0; end
          end
        endcase
      end
    end
  end

  task automatic send(input bit dr, input logic [7:0] d, input bit drr,
                      input logic [10:0] p, input logic [3:0] ev, input bit push);
    @(negedge clk);
    rsp_valid = dr; rsp_data = d; rr_valid = drr; rr_period = p; evt_req = ev;
    if (push) begin
      if (dr) exp_q.push_back(d);
      if (drr) begin
        exp_q.push_back(8'hA5);
        exp_q.push_back({5'b0, p[10:8]});
        exp_q.push_back(p[7:0]);
      end
      for (int i = 0; i < 4; i++)
        if (ev[i]) exp_q.push_back({4'hE, 4'(1 << i)});
    end
    @(negedge clk);
    rsp_valid = 1'b0; rr_valid = 1'b0; evt_req = 4'h0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (idle) break;
    end
    chk(name, idle, 1);
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (tx_busy) break;
    end
    chk("busy_seen", tx_busy, 1);
  endtask

  initial begin
    rst_n = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00; rr_valid = 1'b0;
    rr_period = 11'h0; evt_req = 4'h0; rr_ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_overrun", rr_overrun, 0);
    chk("rst_ready", rsp_ready, 1);
    chk("rst_idle", idle, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single response byte
    send(1, 8'h3C, 0, 11'h0, 4'h0, 1);
    chk("rsp_ready_drop", rsp_ready, 0);
    chk("not_idle", idle, 0);
    wait_idle("rsp_idle");
    chk("idle_after_gap", 32'(((cyc - last_fall) >= GAP) && ((cyc - last_fall) <= GAP + 3)), 1);

    // RR frame
    send(0, 8'h00, 1, 11'h5A3, 4'h0, 1);
    wait_idle("rr_idle");
    chk("rr_no_overrun", rr_overrun, 0);

    // All sources in one cycle
    send(1, 8'h11, 1, 11'h2B7, 4'b0110, 1);
    wait_idle("all_idle");

    // RR overwrite while a response is in flight, plus a merged event re-pulse
    send(1, 8'h77, 0, 11'h0, 4'h0, 1);
    wait_busy();
    send(0, 8'h00, 1, 11'h100, 4'h0, 0);
    send(0, 8'h00, 1, 11'h200, 4'h0, 1);
    chk("overrun_set", rr_overrun, 1);
    send(0, 8'h00, 0, 11'h0, 4'b0010, 1);
    send(0, 8'h00, 0, 11'h0, 4'b0010, 0);
    @(negedge clk); rr_ovr_clr = 1'b1;
    @(negedge clk); rr_ovr_clr = 1'b0;
    chk("overrun_clr", rr_overrun, 0);
    wait_idle("ovr_idle");

    // Response arriving mid RR frame waits for the frame to finish
    send(0, 8'h00, 1, 11'h3C1, 4'h0, 1);
    for (int k = 0; k < 500 && exp_q.size() > 1; k++) @(negedge clk);
    chk("mid_frame_reached", exp_q.size(), 1);
    send(1, 8'h5E, 0, 11'h0, 4'h0, 1);
    wait_idle("mid_idle");

    // Reset while the first RR byte is being transmitted
    send(0, 8'h00, 1, 11'h6D2, 4'h0, 1);
    wait_busy();
    send(1, 8'h99, 0, 11'h0, 4'b1000, 0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_valid", tx_data_valid, 0);
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_ready", rsp_ready, 1);
    chk("rst_mid_data", tx_data, 8'h00);
    rst_n = 1'b1;
    have_fall = 0;
    repeat (300) @(negedge clk);
    chk("post_rst_idle", idle, 1);

    // Randomized mixes issued from quiet
    for (int it = 0; it < 8; it++) begin
      logic [31:0] r;
      bit dr, drr;
      r = $urandom;
      dr = r[0]; drr = r[1];
      if (!dr && !drr && r[7:4] == 4'h0) dr = 1;
      send(dr, r[15:8], drr, r[26:16], r[7:4], 1);
      wait_idle("rand_idle");
      chk("rand_overrun", rr_overrun, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between three byte sources: register read responses, RR-period reports from the detection algorithm, and algorithm event flags.
- Buffers each source, arbitrates only at frame boundaries, frames RR reports with a header, and sequences bytes to the transmitter using a busy-based handshake.
- Sits between the UART register/command logic and uart_transmitter, replacing the direct tx_data/tx_data_valid connection.

Parameters:
- RR_HDR, 8'hA5, header byte that starts an RR report frame.
- EVT_PREFIX, 4'hE, upper nibble of every event byte.
- GAP_CYCLES, 16, minimum clk cycles of idle between transmitted bytes (range 0..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rsp_valid  in  1  register read-response byte offered.
- rsp_data  in  8  response byte.
- rsp_ready  out  1  response buffer empty; capture occurs on rsp_valid & rsp_ready.
- rr_valid  in  1  one-cycle pulse: new RR period available.
- rr_period  in  11  RR period value; sampled on rr_valid.
- evt_req  in  4  one-cycle event pulses (bit i = event i).
- tx_busy  in  1  transmitter busy.
- tx_data  out  8  byte to transmit.
- tx_data_valid  out  1  byte request to transmitter.
- rr_ovr_clr  in  1  clears rr_overrun.
- rr_overrun  out  1  sticky: an unsent RR report was overwritten.
- idle  out  1  FSM in IDLE and no pending source.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Asserting rst_n aborts any frame in progress; nothing resumes after release.
- Reset values: all buffers empty, evt mask 0, tx_data 8'h00, tx_data_valid 0, rr_overrun 0, rsp_ready 1, idle 1, FSM IDLE.
- Response buffer:
  - One byte deep. rsp_ready = ~rsp_pend.
  - rsp_pend is set on capture and cleared when the frame is selected.
- RR buffer:
  - rr_valid loads rr_buf and sets rr_pend.
  - rr_valid while rr_pend=1 and the frame is not yet selected: overwrite rr_buf and set rr_overrun.
  - rr_valid in the same cycle as selection: new value pends, no overrun.
- Event mask:
  - pend_mask |= evt_req each cycle.
  - Selection clears the served bit. A re-pulse of that bit in the same cycle keeps it set.
- Arbitration:
  - Evaluated only in IDLE. Fixed priority: rsp > rr > evt; for events, the lowest set bit wins.
  - Selection copies the frame into a 3-byte shift register and sets the length: rsp = 1 byte; rr = 3 bytes {RR_HDR, {5'b0, rr[10:8]}, rr[7:0]}; evt i = 1 byte {EVT_PREFIX, one-hot(i)}.
  - IDLE → ISSUE the cycle after selection.
- ISSUE:
  - tx_data_valid=1 with tx_data = current byte, held stable until tx_busy=1 is sampled.
  - Then deassert tx_data_valid and go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then go to GAP with the counter loaded to GAP_CYCLES.
- GAP:
  - Decrement the counter; at 0, if bytes remain, shift and go to ISSUE, else go to IDLE.
  - GAP_CYCLES=0 passes through GAP in one cycle.
- Frames are never interleaved. A higher-priority request arriving mid-frame waits for IDLE.
- rr_ovr_clr clears rr_overrun. A simultaneous set takes priority over the clear.
- idle = (state==IDLE) & ~rsp_pend & ~rr_pend & (pend_mask==0).

Test Plan:
- Transmitter model asserts tx_busy 3 cycles after tx_data_valid and holds it 20 cycles; rsp_data=8'h3C → rsp_ready drops, exactly one byte 8'h3C, tx_data_valid drops the cycle after busy is seen, idle returns after GAP_CYCLES.
- rr_valid with rr_period=11'h5A3 → bytes 8'hA5, 8'h05, 8'hA3 in order, each separated by at least 16 idle cycles; rr_overrun stays 0.
- rsp, rr and evt_req=4'b0110 all in the same cycle → frame order: rsp byte, RR frame (3 bytes), 8'hE2, 8'hE4.
- rr_valid twice (11'h100, then 11'h200) before selection → one frame {A5, 02, 00}, rr_overrun=1; rr_ovr_clr → rr_overrun=0.
- rsp_valid arrives during the 2nd byte of an RR frame → RR frame completes uninterrupted, then the response byte is sent.
- rst_n asserted while in WAIT_DONE of an RR frame → tx_data_valid=0, idle=1, buffers cleared; no remaining bytes sent after release.
